// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared field positions, immediate widths and decoded bundle type
package core_pkg;
  localparam int CORE_DATA_W = 16;
  localparam int CORE_REG_AW = 3;
  localparam int RA_LSB      = 10;
  localparam int RB_LSB      = 7;
  localparam int RC_LSB      = 0;
  localparam int IMM7_W      = 7;
  localparam int IMM10_W     = 10;

  typedef struct packed {
    logic [CORE_DATA_W-1:0] ra;
    logic [CORE_DATA_W-1:0] rb;
    logic [CORE_DATA_W-1:0] rc;
    logic [CORE_REG_AW-1:0] ra_idx;
    logic [CORE_REG_AW-1:0] rb_idx;
    logic [CORE_REG_AW-1:0] rc_idx;
    logic [IMM7_W-1:0]      imm7;
    logic [IMM10_W-1:0]     imm10;
  } bundle_t;
endpackage

// File: rtl/decode_regread_stage_regfile_bypass.sv
// rtl/decode_regread_stage_regfile_bypass.sv - register storage with one write port
// and NUM_RD combinational read ports that forward the same-cycle write.
module regfile_bypass #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int NUM_RD  = 3,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [REG_AW-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*REG_AW-1:0] rd_idx,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);
  localparam int NUM_REGS = 2**REG_AW;

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic              wr_ok;
  logic [REG_AW-1:0] idx;
  logic [DATA_W-1:0] val;

  assign wr_ok = wr_en && !(R0_ZERO && (wr_addr == '0));

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data = '0;
    idx     = '0;
    val     = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      idx = rd_idx[r*REG_AW +: REG_AW];
      val = mem_q[idx];
      if (wr_ok && (wr_addr == idx)) val = wr_data;
      if (R0_ZERO && (idx == '0)) val = '0;
      rd_data[r*DATA_W +: DATA_W] = val;
    end
  end
endmodule

// File: rtl/decode_regread_stage.sv
// rtl/decode_regread_stage.sv - decode/register-read stage: field decode, bypassed
// operand read, pending-write scoreboard and a one-entry valid/ready output register.
module decode_regread_stage
  import core_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int INSTR_W = 16,
  parameter int RA_LSB  = core_pkg::RA_LSB,
  parameter int RB_LSB  = core_pkg::RB_LSB,
  parameter int RC_LSB  = core_pkg::RC_LSB,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_ra,
  output logic [DATA_W-1:0]   out_rb,
  output logic [DATA_W-1:0]   out_rc,
  output logic [REG_AW-1:0]   out_ra_idx,
  output logic [REG_AW-1:0]   out_rb_idx,
  output logic [REG_AW-1:0]   out_rc_idx,
  output logic [IMM7_W-1:0]   out_imm7,
  output logic [IMM10_W-1:0]  out_imm10,
  input  logic                wr_en,
  input  logic [REG_AW-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                mark_en,
  input  logic [REG_AW-1:0]   mark_addr,
  output logic                hazard
);
  localparam int NUM_REGS = 2**REG_AW;

  typedef struct packed {
    logic [DATA_W-1:0]  ra;
    logic [DATA_W-1:0]  rb;
    logic [DATA_W-1:0]  rc;
    logic [REG_AW-1:0]  ra_idx;
    logic [REG_AW-1:0]  rb_idx;
    logic [REG_AW-1:0]  rc_idx;
    logic [IMM7_W-1:0]  imm7;
    logic [IMM10_W-1:0] imm10;
  } stage_bundle_t;

  logic [REG_AW-1:0]   ra_idx, rb_idx, rc_idx;
  logic [DATA_W-1:0]   ra_val, rb_val, rc_val;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  stage_bundle_t       bundle_q, bundle_d;
  logic                out_valid_q, out_valid_d;
  logic                src_busy, accept;
  logic                unused_instr_bits;

  assign ra_idx = in_instr[RA_LSB +: REG_AW];
  assign rb_idx = in_instr[RB_LSB +: REG_AW];
  assign rc_idx = in_instr[RC_LSB +: REG_AW];
  assign unused_instr_bits = ^in_instr;

  regfile_bypass #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .NUM_RD (3),
    .R0_ZERO(R0_ZERO)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_idx ({rc_idx, rb_idx, ra_idx}),
    .rd_data({rc_val, rb_val, ra_val})
  );

  // A pending source being written this cycle is not a stall: the bypass supplies it.
  function automatic logic busy(input logic [REG_AW-1:0] idx);
    return pend_q[idx] && !(wr_en && (wr_addr == idx));
  endfunction

  function automatic logic [DATA_W-1:0] refresh(input logic [REG_AW-1:0] idx,
                                                input logic [DATA_W-1:0] cur);
    if (wr_en && (wr_addr == idx) && !(R0_ZERO && (idx == '0))) return wr_data;
    return cur;
  endfunction

  assign src_busy = busy(ra_idx) || busy(rb_idx) || busy(rc_idx);
  assign hazard   = in_valid && src_busy;
  assign in_ready = !rst && !src_busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Mark after clear so a same-cycle mark/write leaves the register pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_en)   pend_d[wr_addr]   = 1'b0;
    if (mark_en) pend_d[mark_addr] = 1'b1;
    if (R0_ZERO) pend_d[0]         = 1'b0;
  end

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      bundle_d.ra     = ra_val;
      bundle_d.rb     = rb_val;
      bundle_d.rc     = rc_val;
      bundle_d.ra_idx = ra_idx;
      bundle_d.rb_idx = rb_idx;
      bundle_d.rc_idx = rc_idx;
      bundle_d.imm7   = in_instr[IMM7_W-1:0];
      bundle_d.imm10  = in_instr[IMM10_W-1:0];
      out_valid_d     = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      bundle_d.ra = refresh(bundle_q.ra_idx, bundle_q.ra);
      bundle_d.rb = refresh(bundle_q.rb_idx, bundle_q.rb);
      bundle_d.rc = refresh(bundle_q.rc_idx, bundle_q.rc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ra     = bundle_q.ra;
  assign out_rb     = bundle_q.rb;
  assign out_rc     = bundle_q.rc;
  assign out_ra_idx = bundle_q.ra_idx;
  assign out_rb_idx = bundle_q.rb_idx;
  assign out_rc_idx = bundle_q.rc_idx;
  assign out_imm7   = bundle_q.imm7;
  assign out_imm10  = bundle_q.imm10;
endmodule

// File: tb/tb_decode_regread_stage.sv
// tb/tb_decode_regread_stage.sv - directed vector bench for decode_regread_stage
module tb_decode_regread_stage;
  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [15:0] in_instr;
  logic        out_valid, out_ready;
  logic [15:0] out_ra, out_rb, out_rc;
  logic [2:0]  out_ra_idx, out_rb_idx, out_rc_idx;
  logic [6:0]  out_imm7;
  logic [9:0]  out_imm10;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        mark_en;
  logic [2:0]  mark_addr;
  logic        hazard;

  int n_chk = 0;
  int n_fail = 0;

  decode_regread_stage #(.R0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc),
    .out_ra_idx(out_ra_idx), .out_rb_idx(out_rb_idx), .out_rc_idx(out_rc_idx),
    .out_imm7(out_imm7), .out_imm10(out_imm10),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] instr;
    logic [15:0] e_ra, e_rb, e_rc;
    logic [6:0]  e_imm7;
    logic [9:0]  e_imm10;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcvd, cyc;
    logic acc, cons;

    vt[0] = '{1'b0, 3'd0, 16'h0000, 16'h0D83, 16'h1234, 16'h1234, 16'h1234, 7'h03, 10'h183};
    vt[1] = '{1'b0, 3'd0, 16'h0000, 16'h052C, 16'h1111, 16'h2222, 16'h4444, 7'h2C, 10'h12C};
    vt[2] = '{1'b1, 3'd5, 16'hBEEF, 16'h9407, 16'hBEEF, 16'h0000, 16'h7777, 7'h07, 10'h007};
    vt[3] = '{1'b1, 3'd0, 16'hFFFF, 16'h0280, 16'h0000, 16'hBEEF, 16'h0000, 7'h00, 10'h280};
    vt[4] = '{1'b0, 3'd0, 16'h0000, 16'h1F79, 16'h7777, 16'h6666, 16'h1111, 7'h79, 10'h379};
    vt[5] = '{1'b1, 3'd6, 16'h0BAD, 16'h1B06, 16'h0BAD, 16'h0BAD, 16'h0BAD, 7'h06, 10'h306};
    vt[6] = '{1'b0, 3'd0, 16'h0000, 16'h0D83, 16'h1234, 16'h1234, 16'h1234, 7'h03, 10'h183};
    vt[7] = '{1'b0, 3'd0, 16'h0000, 16'h0A05, 16'h2222, 16'h4444, 16'hBEEF, 7'h05, 10'h205};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; mark_en = 1'b0; mark_addr = '0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_ra", out_ra, 0);
    chk("rst_out_imm10", out_imm10, 0);
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    wr(3'd0, 16'hFFFF);
    wr(3'd1, 16'h1111); wr(3'd2, 16'h2222); wr(3'd3, 16'h1234); wr(3'd4, 16'h4444);
    wr(3'd5, 16'h5A5A); wr(3'd6, 16'h6666); wr(3'd7, 16'h7777);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = vt[i].wr_en; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
      in_valid = 1'b1; in_instr = vt[i].instr;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      tick();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_ra", i), out_ra, vt[i].e_ra);
      chk($sformatf("v%0d_rb", i), out_rb, vt[i].e_rb);
      chk($sformatf("v%0d_rc", i), out_rc, vt[i].e_rc);
      chk($sformatf("v%0d_imm7", i), out_imm7, vt[i].e_imm7);
      chk($sformatf("v%0d_imm10", i), out_imm10, vt[i].e_imm10);
    end
    wr_en = 1'b0; in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_hold_ra", out_ra, 16'h2222);

    mark_en = 1'b1; mark_addr = 3'd2;
    tick();
    mark_en = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("sb_hazard_c%0d", c), hazard, 1);
      chk($sformatf("sb_in_ready_c%0d", c), in_ready, 0);
      tick();
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0042;
    #1;
    chk("sb_clear_hazard", hazard, 0);
    chk("sb_clear_in_ready", in_ready, 1);
    tick();
    wr_en = 1'b0; in_valid = 1'b0;
    chk("sb_clear_valid", out_valid, 1);
    chk("sb_clear_rb", out_rb, 16'h0042);
    chk("sb_clear_rb_idx", out_rb_idx, 3'd2);

    mark_en = 1'b1; wr_en = 1'b1; mark_addr = 3'd2; wr_addr = 3'd2; wr_data = 16'h0077;
    tick();
    mark_en = 1'b0; wr_en = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0100;
    #1;
    chk("sb_set_wins_hazard", hazard, 1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0099;
    #1;
    chk("sb_bypass_in_ready", in_ready, 1);
    tick();
    wr_en = 1'b0; in_valid = 1'b0;
    chk("sb_bypass_rb", out_rb, 16'h0099);

    mark_en = 1'b1; mark_addr = 3'd0;
    tick();
    mark_en = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0000;
    #1;
    chk("r0_never_pending", hazard, 0);
    tick();
    in_valid = 1'b0;
    tick();

    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h1000;
    tick();
    in_valid = 1'b0;
    chk("stall_valid", out_valid, 1);
    chk("stall_ra", out_ra, 16'h4444);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h5555;
    #1;
    chk("stall_in_ready", in_ready, 0);
    tick();
    wr_en = 1'b0;
    chk("stall_refresh_ra", out_ra, 16'h5555);
    chk("stall_refresh_rb", out_rb, 16'h0000);
    chk("stall_still_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("stall_release", out_valid, 0);

    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0D83;
    tick();
    in_valid = 1'b0;
    chk("rstmid_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_ra", out_ra, 0);
    chk("rstmid_imm10", out_imm10, 0);
    chk("rstmid_in_ready", in_ready, 0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("rstmid_dropped", out_valid, 0);
    in_valid = 1'b1; in_instr = 16'h0D83;
    tick();
    in_valid = 1'b0;
    chk("rstmid_regs_clear", out_ra, 0);
    chk("rstmid_new_valid", out_valid, 1);
    tick();

    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 20 && cyc < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 20);
      in_instr  = 16'(sent);
      #1;
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        chk($sformatf("stream_order_%0d", rcvd), out_imm7, 7'(rcvd));
        rcvd++;
      end
      tick();
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", rcvd, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
